// File: rtl/red_pitaya_daisy_pkg.sv
// Shared definitions for the daisy-chain link: TX state encoding and the framing
// constants that the receiver also relies on.
package red_pitaya_daisy_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_TRAIN    = 2'd1,
    ST_RUN      = 2'd2
  } daisy_st_e;

  localparam logic [15:0] DAISY_TRAIN_WORD   = 16'h00FF;
  localparam int unsigned DAISY_NIB_PER_WORD = 4;

endpackage

// File: rtl/red_pitaya_daisy_tx_fifo.sv
// Single-clock word FIFO for the daisy TX path. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate count.
module red_pitaya_daisy_tx_fifo
  import red_pitaya_daisy_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign pop_ok_s  = pop && !empty;
  // A pop on a full FIFO frees the slot the same cycle, so the push may land there.
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/red_pitaya_daisy_tx.sv
// Daisy-chain transmitter: buffers parallel words and emits them as 4-bit nibbles,
// LSB nibble first, to an external OSERDES; sends 16'h00FF while training.
module red_pitaya_daisy_tx
  import red_pitaya_daisy_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] IDLE_WORD = 16'h0000
) (
  input  logic        par_clk_i,
  input  logic        par_rst_i,
  input  logic        cfg_en_i,
  input  logic        cfg_train_i,
  input  logic [15:0] par_dat_i,
  input  logic        par_dv_i,
  output logic        par_rdy_o,
  output logic [3:0]  ser_nib_o,
  output logic        ser_sow_o,
  output logic        sts_train_o,
  output logic [31:0] sts_cnt_o
);

  localparam logic [1:0] NIB_LAST = 2'(DAISY_NIB_PER_WORD - 1);

  logic [1:0]  en_sync_r;
  logic [1:0]  train_sync_r;
  logic        en_s;
  logic        train_s;
  logic [1:0]  nib_cnt_r;
  daisy_st_e   st_r;
  daisy_st_e   st_nxt_s;
  logic        load_s;
  logic        pop_s;
  logic        push_s;
  logic        flush_s;
  logic        full_s;
  logic        empty_s;
  logic [15:0] head_s;
  logic [15:0] load_word_s;
  logic [11:0] shift_r;

  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      en_sync_r    <= 2'b00;
      train_sync_r <= 2'b00;
    end else begin
      en_sync_r    <= {en_sync_r[0], cfg_en_i};
      train_sync_r <= {train_sync_r[0], cfg_train_i};
    end
  end

  assign en_s    = en_sync_r[1];
  assign train_s = train_sync_r[1];

  // Free-running nibble counter fixes the word framing in every state.
  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      nib_cnt_r <= 2'd0;
    end else begin
      nib_cnt_r <= nib_cnt_r + 2'd1;
    end
  end

  assign load_s = (nib_cnt_r == NIB_LAST);

  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      st_r <= ST_DISABLED;
    end else if (load_s) begin
      st_r <= st_nxt_s;
    end
  end

  // Next state and the word to load; the word always reflects the new state.
  always_comb begin
    st_nxt_s    = st_r;
    load_word_s = 16'h0000;
    pop_s       = 1'b0;
    case (st_r)
      ST_DISABLED, ST_TRAIN, ST_RUN: begin
        if (!en_s) begin
          st_nxt_s = ST_DISABLED;
        end else if (train_s) begin
          st_nxt_s = ST_TRAIN;
        end else begin
          st_nxt_s = ST_RUN;
        end
      end
      default: st_nxt_s = ST_DISABLED;
    endcase
    case (st_nxt_s)
      ST_TRAIN: load_word_s = DAISY_TRAIN_WORD;
      ST_RUN: begin
        if (!empty_s) begin
          load_word_s = head_s;
          pop_s       = load_s;
        end else begin
          load_word_s = IDLE_WORD;
        end
      end
      default: load_word_s = 16'h0000;
    endcase
  end

  assign flush_s   = (st_r == ST_DISABLED) || (load_s && (st_nxt_s == ST_DISABLED));
  assign par_rdy_o = (st_r != ST_DISABLED) && (!full_s || pop_s);
  assign push_s    = par_dv_i && par_rdy_o;

  red_pitaya_daisy_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk      (par_clk_i),
    .rst      (par_rst_i),
    .flush    (flush_s),
    .push     (push_s),
    .push_dat (par_dat_i),
    .pop      (pop_s),
    .head     (head_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Nibble [3:0] goes out with the load; the upper three drain from shift_r.
  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      ser_nib_o   <= 4'h0;
      ser_sow_o   <= 1'b0;
      sts_train_o <= 1'b0;
      sts_cnt_o   <= 32'd0;
      shift_r     <= 12'h000;
    end else if (load_s) begin
      ser_nib_o   <= load_word_s[3:0];
      shift_r     <= load_word_s[15:4];
      ser_sow_o   <= 1'b1;
      sts_train_o <= (st_nxt_s == ST_TRAIN);
      if (pop_s) begin
        sts_cnt_o <= sts_cnt_o + 32'd1;
      end
    end else begin
      ser_nib_o <= shift_r[3:0];
      shift_r   <= {4'h0, shift_r[11:4]};
      ser_sow_o <= 1'b0;
    end
  end

endmodule
